scene_sequencer: RTL and testbench
==================================

// Module: scene_sequencer
// PURPOSE
//   Frame-synchronous controller for the VGA sine-wave scene. Runs on the pixel
//   clock, derives a per-frame tick from hpos/vpos and sequences the game:
//   idle -> intro -> run <-> pause -> over. Drives the scroll offset, player
//   visibility, jump lift and score consumed by the scene/player renderers;
//   replaces clocking animation state on the vsync edge.
// PARAMETERS
//   V_ACTIVE      480  visible lines; frame tick fires at start of line V_ACTIVE
//   WRAP          400  scroll period in pixels; x_offset range 0..WRAP-1
//   STEP_BASE     2    pixels scrolled per frame at speed=0
//   INTRO_FRAMES  60   frames spent in INTRO before RUN
//   JUMP_FRAMES   16   jump duration in frames (even, <=30)
//   BLINK_LOG2    3    OVER-state blink half-period = 2**BLINK_LOG2 frames
// PORTS
//   clk          in   1   pixel clock
//   rst_n        in   1   reset; one clock, asynchronous assert, active-low
//   hpos         in   10  horizontal counter from hvsync_generator
//   vpos         in   10  vertical counter from hvsync_generator
//   btn_start    in   1   raw start button, async, active-high
//   btn_pause    in   1   raw pause toggle, async, active-high
//   btn_jump     in   1   raw jump button, async, active-high
//   speed        in   2   scroll speed select, sampled at frame tick
//   hit          in   1   player/sine pixel overlap from compositor
//   frame_tick   out  1   1-cycle pulse, hpos==0 && vpos==V_ACTIVE
//   state        out  3   0 IDLE, 1 INTRO, 2 RUN, 3 PAUSE, 4 OVER
//   x_offset     out  10  scroll offset to scene and player LUT address
//   show_player  out  1   player enable
//   jump_lift    out  5   upward player displacement in pixels (0..JUMP_FRAMES)
//   score        out  8   completed scroll periods, saturating at 255
// BEHAVIOUR
//   - Reset: state=IDLE, x_offset=0, show_player=0, jump_lift=0, score=0,
//     frame_tick=0, all pending/sticky flags and counters 0. Reset mid-frame or
//     mid-jump returns to these values immediately; no partial frame kept.
//   - All outputs except frame_tick change only on the cycle after frame_tick,
//     so they are stable through active video.
//   - Buttons: 2-FF sync, rising-edge detect, set a pending flag. Flags are
//     sampled and cleared on every frame_tick, whether consumed or not.
//     Several presses in one frame = one event. An edge that coincides with the
//     tick cycle carries to the next frame.
//   - hit_seen: sticky, set when hit=1 && vpos<V_ACTIVE; sampled/cleared on tick.
//   - FSM, evaluated on frame_tick only:
//     IDLE : offset held 0, show_player=0; start -> INTRO (score cleared).
//     INTRO: show_player=1, offset frozen; count INTRO_FRAMES ticks -> RUN.
//     RUN  : sum = x_offset + STEP_BASE*(speed+1) in 11 bits; if sum>=WRAP then
//            x_offset=sum-WRAP, score+=1 (saturate), else x_offset=sum.
//            Priority: hit_seen -> OVER; else pause -> PAUSE; start ignored.
//     PAUSE: offset, jump and score frozen; pause -> RUN; start/jump ignored.
//     OVER : offset frozen; show_player toggles every 2**BLINK_LOG2 ticks;
//            start -> IDLE (offset=0, score=0, jump_lift=0).
//   - Jump: in RUN, jump pending with jump counter idle starts jump; counter
//     k=1..JUMP_FRAMES; lift = 2*k for k<=J/2, 2*(J-k) after; returns to 0.
//     Jump pressed during a jump is dropped. Entering OVER/IDLE zeroes lift.
//   - frame_tick pulses in every state, including IDLE.
// STRUCTURE
//   - Package scene_pkg: state encoding localparams, V_ACTIVE, WRAP, shared
//     with hvsync_generator and create_game_scene.
//   - Sub-module btn_sync_pend (sync, edge detect, pending flag with clear
//     input), instantiated three times. FSM, scroll and jump logic inline.
// TESTING
//   - Reset then 3 frames, no buttons -> state=0, x_offset=0, show_player=0,
//     one frame_tick per 800*525 clocks.
//   - start pulse frame 0 -> INTRO 60 ticks, RUN on tick 61; speed=0 -> offset
//     2,4,...,398,0; score=1 at first wrap.
//   - RUN speed=3, offset=396 -> next offset 4 (396+8-400), score+1; score
//     at 255 stays 255 on further wraps.
//   - pause and hit pulses in same frame -> OVER, not PAUSE; then start -> IDLE,
//     offset=0, score=0; show_player toggles every 8 ticks in OVER.
//   - jump in RUN, JUMP_FRAMES=16 -> lift 2,4..16,14..0 over 16 ticks; second
//     jump press mid-jump ignored; pause mid-jump freezes lift.
//   - rst_n low mid-jump during active video -> all outputs to reset values
//     asynchronously; two start presses in one frame give a single INTRO.

Source files
------------

// File: rtl/scene_sequencer_pkg.sv
// Shared constants and state encoding for the sine-wave scene game.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scene_sequencer_pkg;

  localparam int V_ACTIVE     = 480;  // visible lines; frame tick at start of line V_ACTIVE
  localparam int WRAP         = 400;  // scroll period in pixels
  localparam int STEP_BASE    = 2;    // pixels per frame at speed 0
  localparam int INTRO_FRAMES = 60;   // frames spent in INTRO
  localparam int JUMP_FRAMES  = 16;   // jump duration in frames (even, <= 30)
  localparam int BLINK_LOG2   = 3;    // OVER blink half-period = 2**BLINK_LOG2 frames

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INTRO = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Triangular jump profile: rises 2 px per frame to the apex, then falls back to 0.
  function automatic logic [4:0] jump_profile(input int k, input int frames);
    if (k <= frames / 2) return 5'(2 * k);
    else                 return 5'(2 * (frames - k));
  endfunction

endpackage

// File: rtl/scene_sequencer_if.sv
// Signal bundle between the video timing/compositor side and the scene sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level or single-cycle pulses.
// Ports: raster position, raw buttons, speed, hit in; tick, state, scroll, player controls, score out.
interface scene_sequencer_if;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       btn_start;
  logic       btn_pause;
  logic       btn_jump;
  logic [1:0] speed;
  logic       hit;
  logic       frame_tick;
  logic [2:0] state;
  logic [9:0] x_offset;
  logic       show_player;
  logic [4:0] jump_lift;
  logic [7:0] score;

  modport master (
    output hpos, vpos, btn_start, btn_pause, btn_jump, speed, hit,
    input  frame_tick, state, x_offset, show_player, jump_lift, score
  );

  modport slave (
    input  hpos, vpos, btn_start, btn_pause, btn_jump, speed, hit,
    output frame_tick, state, x_offset, show_player, jump_lift, score
  );
endinterface

// File: rtl/scene_sequencer_btn.sv
// Button conditioner: 2-FF synchroniser, rising-edge detect, pending flag.
// Latency: an input edge sets pend 3 clocks later.
// Backpressure: none; clr drops older events, an edge arriving on the clr cycle survives.
// Ports: clk, rst_n, btn (async raw), clr (frame tick), pend (event waiting for next tick).
module btn_sync_pend (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic clr,
  output logic pend
);
  logic [2:0] sh;   // [1:0] synchroniser, [2] previous synced level
  logic       rise;

  assign rise = sh[1] & ~sh[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      pend <= 1'b0;
    end else begin
      sh   <= {sh[1:0], btn};
      // On clear the flag restarts from this cycle's edge so it is not lost.
      pend <= clr ? rise : (pend | rise);
    end
  end
endmodule

// File: rtl/scene_sequencer.sv
// Frame-synchronous game sequencer: idle -> intro -> run <-> pause -> over.
// Latency: frame_tick one clock after hpos==0 && vpos==V_ACTIVE; other outputs update the clock after.
// Backpressure: none; button events are merged per frame and sampled on the tick.
// Ports: clk, rst_n, bus (slave: raster/buttons/speed/hit in; tick/state/scroll/player/score out).
module scene_sequencer
  import scene_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  scene_sequencer_if.slave   bus
);
  localparam int INTRO_W = $clog2(INTRO_FRAMES);
  localparam int JUMP_W  = $clog2(JUMP_FRAMES + 1);

  logic                  tick_q;
  logic                  start_p, pause_p, jump_p;
  logic                  hit_act, hit_seen_q;
  state_t                state_q, state_n;
  logic [9:0]            off_q, off_n;
  logic                  show_q, show_n;
  logic [JUMP_W-1:0]     jcnt_q, jcnt_n;      // 0 = no jump, else frame index 1..JUMP_FRAMES
  logic [7:0]            score_q, score_n;
  logic [INTRO_W-1:0]    intro_q, intro_n;
  logic [BLINK_LOG2-1:0] blink_q, blink_n;
  logic [10:0]           sum;

  btn_sync_pend u_start (.clk(clk), .rst_n(rst_n), .btn(bus.btn_start), .clr(tick_q), .pend(start_p));
  btn_sync_pend u_pause (.clk(clk), .rst_n(rst_n), .btn(bus.btn_pause), .clr(tick_q), .pend(pause_p));
  btn_sync_pend u_jump  (.clk(clk), .rst_n(rst_n), .btn(bus.btn_jump),  .clr(tick_q), .pend(jump_p));

  // Overlap only counts while the beam is in the visible area.
  assign hit_act = bus.hit && (bus.vpos < 10'(V_ACTIVE));
  assign sum     = {1'b0, off_q} + 11'(STEP_BASE * (int'(bus.speed) + 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q     <= 1'b0;
      hit_seen_q <= 1'b0;
      state_q    <= ST_IDLE;
      off_q      <= '0;
      show_q     <= 1'b0;
      jcnt_q     <= '0;
      score_q    <= '0;
      intro_q    <= '0;
      blink_q    <= '0;
    end else begin
      tick_q     <= (bus.hpos == 10'd0) && (bus.vpos == 10'(V_ACTIVE));
      hit_seen_q <= tick_q ? hit_act : (hit_seen_q | hit_act);
      state_q    <= state_n;
      off_q      <= off_n;
      show_q     <= show_n;
      jcnt_q     <= jcnt_n;
      score_q    <= score_n;
      intro_q    <= intro_n;
      blink_q    <= blink_n;
    end
  end

  always_comb begin
    state_n = state_q;
    off_n   = off_q;
    show_n  = show_q;
    jcnt_n  = jcnt_q;
    score_n = score_q;
    intro_n = intro_q;
    blink_n = blink_q;
    if (tick_q) begin
      unique case (state_q)
        ST_IDLE: begin
          off_n  = '0;
          show_n = 1'b0;
          jcnt_n = '0;
          if (start_p) begin
            state_n = ST_INTRO;
            score_n = '0;
            show_n  = 1'b1;
            intro_n = '0;
          end
        end
        ST_INTRO: begin
          show_n = 1'b1;
          if (intro_q == INTRO_W'(INTRO_FRAMES - 1)) state_n = ST_RUN;
          else                                       intro_n = intro_q + INTRO_W'(1);
        end
        ST_RUN: begin
          if (sum >= 11'(WRAP)) begin
            off_n = 10'(sum - 11'(WRAP));
            if (score_q != 8'hFF) score_n = score_q + 8'd1;
          end else begin
            off_n = sum[9:0];
          end
          // A press while a jump is in flight is simply dropped.
          if (jcnt_q != '0)
            jcnt_n = (jcnt_q == JUMP_W'(JUMP_FRAMES)) ? '0 : jcnt_q + JUMP_W'(1);
          else if (jump_p)
            jcnt_n = JUMP_W'(1);
          if (hit_seen_q) begin
            state_n = ST_OVER;
            jcnt_n  = '0;
            blink_n = '0;
          end else if (pause_p) begin
            state_n = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pause_p) state_n = ST_RUN;
        end
        ST_OVER: begin
          blink_n = blink_q + BLINK_LOG2'(1);
          if (blink_q == '1) show_n = ~show_q;
          if (start_p) begin
            state_n = ST_IDLE;
            off_n   = '0;
            score_n = '0;
            jcnt_n  = '0;
            show_n  = 1'b0;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.frame_tick  = tick_q;
  assign bus.state       = state_q;
  assign bus.x_offset    = off_q;
  assign bus.show_player = show_q;
  assign bus.jump_lift   = jump_profile(int'(jcnt_q), JUMP_FRAMES);
  assign bus.score       = score_q;
endmodule

// File: tb/tb_scene_sequencer.sv
// Directed-plus-random bench for scene_sequencer using compressed frames.
// Latency: a frame is nact visible cycles, the tick line start, and one blank cycle.
// Backpressure: n/a.
module tb_scene_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Frame-level reference model of the game.
  int m_state, m_off, m_score, m_jump, m_intro, m_over;
  bit m_show;
  bit c_start, c_pause, c_jump;   // edges that landed on the tick cycle, owed to next frame

  always #5 clk = ~clk;

  scene_sequencer_if bus ();
  scene_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  function automatic int exp_lift(input int k);
    int d;
    d = 2 * k - 16;
    if (d < 0) d = -d;
    return 16 - d;
  endfunction

  task automatic model_reset();
    m_state = 0; m_off = 0; m_score = 0; m_jump = 0; m_intro = 0; m_over = 0;
    m_show = 0; c_start = 0; c_pause = 0; c_jump = 0;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_state"},  32'(bus.state), m_state);
    chk({ph, "_offset"}, 32'(bus.x_offset), m_off);
    chk({ph, "_show"},   32'(bus.show_player), 32'(m_show));
    chk({ph, "_lift"},   32'(bus.jump_lift), exp_lift(m_jump));
    chk({ph, "_score"},  32'(bus.score), m_score);
  endtask

  // A button edge needs two synchroniser clocks; if it surfaces on the tick cycle
  // itself it belongs to the following frame.
  function automatic void edges(input logic [3:0] m, input int nact, output bit now, output bit late);
    bit prev;
    prev = 0; now = 0; late = 0;
    for (int j = 0; j < nact; j++) begin
      if (m[j] && !prev) begin
        if (j <= nact - 2) now = 1;
        else               late = 1;
      end
      prev = m[j];
    end
  endfunction

  task automatic apply_tick(input bit st, input bit ps, input bit jp, input bit ht, input int spd);
    int adv;
    case (m_state)
      0: begin
        m_off = 0; m_show = 0; m_jump = 0;
        if (st) begin m_state = 1; m_score = 0; m_show = 1; m_intro = 0; end
      end
      1: begin
        m_show = 1;
        m_intro++;
        if (m_intro == 60) m_state = 2;
      end
      2: begin
        adv     = m_off + 2 * (spd + 1);
        m_score = m_score + adv / 400;
        if (m_score > 255) m_score = 255;
        m_off   = adv % 400;
        if (m_jump > 0) m_jump = (m_jump == 16) ? 0 : m_jump + 1;
        else if (jp)    m_jump = 1;
        if (ht) begin m_state = 4; m_jump = 0; m_over = 0; end
        else if (ps) m_state = 3;
      end
      3: if (ps) m_state = 2;
      4: begin
        m_over++;
        m_show = ((m_over / 8) % 2) == 0;
        if (st) begin m_state = 0; m_off = 0; m_score = 0; m_jump = 0; m_show = 0; end
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic frame(input int nact, input logic [3:0] st, input logic [3:0] ps,
                       input logic [3:0] jp, input logic [3:0] ht, input logic [1:0] spd);
    bit s_now, s_late, p_now, p_late, j_now, j_late, hit_ev;
    bus.speed = spd;
    hit_ev = 0;
    for (int j = 0; j < nact; j++) begin
      bus.hpos = 10'($urandom_range(0, 799));
      bus.vpos = 10'($urandom_range(0, 479));
      bus.btn_start = st[j]; bus.btn_pause = ps[j]; bus.btn_jump = jp[j];
      bus.hit = ht[j];
      if (ht[j]) hit_ev = 1;
      step();
    end
    // Start of line 480: hit here is outside the visible area.
    bus.hpos = 10'd0; bus.vpos = 10'd480;
    bus.btn_start = 0; bus.btn_pause = 0; bus.btn_jump = 0;
    bus.hit = 1'($urandom_range(0, 1));
    step();
    chk("tick_high", 32'(bus.frame_tick), 1);
    check_outputs("pre");
    bus.hpos = 10'($urandom_range(1, 799));
    bus.vpos = 10'($urandom_range(480, 524));
    bus.hit  = 1'($urandom_range(0, 1));
    step();
    edges(st, nact, s_now, s_late);
    edges(ps, nact, p_now, p_late);
    edges(jp, nact, j_now, j_late);
    apply_tick(s_now | c_start, p_now | c_pause, j_now | c_jump, hit_ev, int'(spd));
    c_start = s_late; c_pause = p_late; c_jump = j_late;
    chk("tick_low", 32'(bus.frame_tick), 0);
    check_outputs("post");
  endtask

  initial begin
    rst_n = 1'b0;
    bus.hpos = '0; bus.vpos = '0; bus.speed = '0; bus.hit = 1'b0;
    bus.btn_start = 1'b0; bus.btn_pause = 1'b0; bus.btn_jump = 1'b0;
    model_reset();
    step(); step();
    check_outputs("reset");
    chk("reset_tick", 32'(bus.frame_tick), 0);
    rst_n = 1'b1;

    // Idle frames: hits and speed have no effect.
    repeat (3) frame(4, 4'h0, 4'h0, 4'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));

    // Two start presses in one frame give one INTRO of exactly 60 frames.
    frame(4, 4'b0101, 4'h0, 4'h0, 4'h0, 2'd0);
    chk("intro_entry", 32'(bus.state), 1);
    repeat (59) frame(4, 4'h0, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'h0, 2'd0);
    chk("intro_held", 32'(bus.state), 1);
    frame(4, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    chk("run_entry", 32'(bus.state), 2);
    chk("run_entry_off", 32'(bus.x_offset), 0);

    // Speed 0 full period, then land on 396 and wrap with speed 3.
    repeat (200) frame(4, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    chk("first_wrap_off", 32'(bus.x_offset), 0);
    chk("first_wrap_score", 32'(bus.score), 1);
    repeat (99) frame(4, 4'h0, 4'h0, 4'h0, 4'h0, 2'd1);
    chk("off_396", 32'(bus.x_offset), 396);
    frame(4, 4'h0, 4'h0, 4'h0, 4'h0, 2'd3);
    chk("wrap_off", 32'(bus.x_offset), 4);
    chk("wrap_score", 32'(bus.score), 2);

    // Random jumps, start presses and speeds while running.
    repeat (60) frame(4, 4'($urandom_range(0, 15)), 4'h0, 4'($urandom_range(0, 15)), 4'h0,
                      2'($urandom_range(0, 3)));

    // Jump, then pause mid-jump freezes the lift.
    repeat (20) frame(4, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    frame(4, 4'h0, 4'h0, 4'b0001, 4'h0, 2'd0);
    chk("jump_first", 32'(bus.jump_lift), 2);
    repeat (4) frame(4, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    frame(4, 4'h0, 4'b0001, 4'h0, 4'h0, 2'd0);
    chk("pause_entry", 32'(bus.state), 3);
    repeat (5) frame(4, 4'($urandom_range(0, 7)), 4'h0, 4'($urandom_range(0, 7)), 4'h0, 2'd2);
    chk("pause_lift", 32'(bus.jump_lift), 12);
    frame(4, 4'h0, 4'b0001, 4'h0, 4'h0, 2'd0);
    chk("resume", 32'(bus.state), 2);
    repeat (15) frame(4, 4'h0, 4'h0, 4'($urandom_range(0, 7)), 4'h0, 2'd1);

    // Pause edge on the tick cycle carries to the next frame.
    frame(4, 4'h0, 4'b1000, 4'h0, 4'h0, 2'd0);
    chk("carry_hold", 32'(bus.state), 2);
    frame(4, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    chk("carry_pause", 32'(bus.state), 3);
    frame(4, 4'h0, 4'b0001, 4'h0, 4'h0, 2'd0);

    // Drive the score into saturation and beyond.
    for (int i = 0; i < 14000 && m_score < 255; i++) frame(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd3);
    repeat (120) frame(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd3);
    chk("score_sat", 32'(bus.score), 255);

    // Hit beats pause in the same frame; then blink in OVER.
    frame(4, 4'h0, 4'b0001, 4'h0, 4'b0100, 2'd0);
    chk("hit_over", 32'(bus.state), 4);
    repeat (8) frame(4, 4'h0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 2'd0);
    chk("blink_off", 32'(bus.show_player), 0);
    repeat (8) frame(4, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    chk("blink_on", 32'(bus.show_player), 1);
    frame(4, 4'b0001, 4'h0, 4'h0, 4'h0, 2'd0);
    chk("over_idle", 32'(bus.state), 0);
    chk("over_idle_score", 32'(bus.score), 0);

    // Second game, then asynchronous reset mid-jump in active video.
    frame(4, 4'b0010, 4'h0, 4'h0, 4'h0, 2'd0);
    repeat (60) frame(4, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    frame(4, 4'h0, 4'h0, 4'b0001, 4'h0, 2'd2);
    repeat (3) frame(4, 4'h0, 4'h0, 4'h0, 4'h0, 2'd2);
    chk("pre_reset_lift", 32'(bus.jump_lift), 8);
    bus.hpos = 10'd100; bus.vpos = 10'd200;
    step();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_rst_tick", 32'(bus.frame_tick), 0);
    step(); step();
    rst_n = 1'b1;
    repeat (3) frame(4, 4'h0, 4'h0, 4'h0, 4'($urandom_range(0, 15)), 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
